// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler: once per blanked line, grants up to MAX_PKTS packet
// slots to the ACR / audio sample / AVI infoframe / audio infoframe builders.
module hdmi_island_scheduler #(
   parameter int PKT_CYCLES    = 32,
   parameter int MAX_PKTS      = 2,
   parameter int ISLAND_OFFSET = 0
) (
   input  logic       i_pixclk,
   input  logic       i_reset,
   input  logic       i_hSync,
   input  logic       i_blank,
   input  logic       i_enable,
   input  logic [3:0] i_req,
   output logic [3:0] o_grant,
   output logic       o_pkt_start,
   output logic       o_island,
   output logic [1:0] o_slot,
   output logic       o_abort
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ARB  = 2'd2;
   localparam logic [1:0] ST_SLOT = 2'd3;

   localparam logic [7:0] SLOT_LAST = 8'(PKT_CYCLES - 1);
   localparam logic [7:0] OFFSET    = 8'(ISLAND_OFFSET);
   localparam logic [2:0] MAX_SLOTS = 3'(MAX_PKTS);

   // Fixed priority audio sample > ACR, then the two infoframes by round-robin (rr=0 favours AVI).
   function automatic logic [3:0] pick(input logic [3:0] avail, input logic rr);
      logic [3:0] g;
      if (avail[1]) begin
         g = 4'b0010;
      end else if (avail[0]) begin
         g = 4'b0001;
      end else if (avail[2] && avail[3]) begin
         g = rr ? 4'b1000 : 4'b0100;
      end else if (avail[2]) begin
         g = 4'b0100;
      end else if (avail[3]) begin
         g = 4'b1000;
      end else begin
         g = 4'b0000;
      end
      return g;
   endfunction

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] served_q, served_d;
   logic       rr_q, rr_d;
   logic       hs_q, hs_d;
   logic       armed_q, armed_d;
   logic [3:0] grant_q, grant_d;
   logic       start_q, start_d;
   logic       island_q, island_d;
   logic [1:0] slot_q, slot_d;
   logic       abort_q, abort_d;

   logic       hs_edge_s;
   logic       trigger_s;
   logic [3:0] avail_s;
   logic [3:0] pick_s;
   logic       more_s;

   // Next-state logic: line trigger, offset wait, arbitration, slot timing and abort.
   always_comb begin
      hs_edge_s = (i_hSync != hs_q);
      trigger_s = hs_edge_s && i_blank && i_enable && armed_q;
      avail_s   = i_req & ~served_q;
      pick_s    = pick(avail_s, rr_q);
      more_s    = (({1'b0, slot_q} + 3'd1) < MAX_SLOTS) && i_enable && (avail_s != 4'b0000);

      state_d  = state_q;
      cnt_d    = cnt_q;
      served_d = served_q;
      rr_d     = rr_q;
      hs_d     = i_hSync;
      grant_d  = grant_q;
      start_d  = 1'b0;
      island_d = island_q;
      slot_d   = slot_q;
      abort_d  = 1'b0;

      // Edges within one blanking period alternate trigger / partner edge.
      if (!i_blank) begin
         armed_d = 1'b1;
      end else if (hs_edge_s) begin
         armed_d = ~armed_q;
      end else begin
         armed_d = armed_q;
      end

      if ((state_q != ST_IDLE) && !i_blank) begin
         abort_d  = (state_q == ST_SLOT);
         state_d  = ST_IDLE;
         cnt_d    = 8'd0;
         grant_d  = 4'b0000;
         island_d = 1'b0;
         slot_d   = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trigger_s) begin
                  state_d  = ST_WAIT;
                  cnt_d    = OFFSET;
                  served_d = 4'b0000;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 8'd0) begin
                  state_d = ST_ARB;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
               end
            end
            ST_ARB: begin
               if (i_enable && (avail_s != 4'b0000)) begin
                  state_d  = ST_SLOT;
                  cnt_d    = SLOT_LAST;
                  grant_d  = pick_s;
                  served_d = served_q | pick_s;
                  start_d  = 1'b1;
                  island_d = 1'b1;
                  slot_d   = 2'd0;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
            ST_SLOT: begin
               if (cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  // Pointer moves only once an infoframe slot completes, so an aborted one retries.
                  if (grant_q[2] || grant_q[3]) begin
                     rr_d = ~rr_q;
                  end else begin
                     rr_d = rr_q;
                  end
                  if (more_s) begin
                     cnt_d    = SLOT_LAST;
                     grant_d  = pick_s;
                     served_d = served_q | pick_s;
                     start_d  = 1'b1;
                     slot_d   = slot_q + 2'd1;
                  end else begin
                     state_d  = ST_IDLE;
                     grant_d  = 4'b0000;
                     island_d = 1'b0;
                     slot_d   = 2'd0;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               grant_d  = 4'b0000;
               island_d = 1'b0;
               slot_d   = 2'd0;
            end
         endcase
      end
   end

   // State and registered outputs; async reset clears everything, pointer back to AVI.
   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         served_q <= 4'b0000;
         rr_q     <= 1'b0;
         hs_q     <= 1'b0;
         armed_q  <= 1'b1;
         grant_q  <= 4'b0000;
         start_q  <= 1'b0;
         island_q <= 1'b0;
         slot_q   <= 2'd0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         served_q <= served_d;
         rr_q     <= rr_d;
         hs_q     <= hs_d;
         armed_q  <= armed_d;
         grant_q  <= grant_d;
         start_q  <= start_d;
         island_q <= island_d;
         slot_q   <= slot_d;
         abort_q  <= abort_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_pkt_start = start_q;
   assign o_island    = island_q;
   assign o_slot      = slot_q;
   assign o_abort     = abort_q;

endmodule
